// File: rtl/dual_port_blockram_controller.sv
`timescale 1ns/1ps
// Request-side controller for a dual_port_blockram: zero-fills the array after every reset, then
// maps a valid/ready request stream onto the blockram ports with an in-order 4-entry response FIFO.
module dual_port_blockram_controller #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = 6
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   request_valid_in,
  output logic                                   request_ready_out,
  input  logic                                   request_write_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       request_set_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] request_data_in,
  output logic                                   response_valid_out,
  input  logic                                   response_ready_in,
  output logic                                   response_write_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       response_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] response_data_out,
  output logic                                   read_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       read_set_addr_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_in,
  output logic                                   write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] evict_element_in,
  output logic                                   init_done_out
);

  localparam int DW = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int AW = SET_PTR_WIDTH_IN_BITS;
  localparam logic [AW-1:0] LAST_SET = AW'(NUMBER_SETS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        r_state;
  logic [AW-1:0] r_init_ptr;
  logic          r_inflight;
  logic          r_tag_write;
  logic [AW-1:0] r_tag_addr;
  logic [2:0]    r_count;
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic [DW-1:0] r_fifo_data  [4];
  logic          r_fifo_write [4];
  logic [AW-1:0] r_fifo_addr  [4];

  logic          w_init_wr;
  logic          w_run;
  logic          w_ready;
  logic          w_accept;
  logic          w_acc_rd;
  logic          w_acc_wr;
  logic          w_resp_valid;
  logic          w_pop;
  logic [DW-1:0] w_push_data;

  // Every output is forced low while reset is asserted so the reset-state values are all zero.
  assign w_init_wr    = (r_state == ST_INIT) && !reset_in;
  assign w_run        = (r_state == ST_RUN) && !reset_in;
  assign w_ready      = w_run && (({1'b0, r_count} + {3'b000, r_inflight}) < 4'd4);
  assign w_accept     = request_valid_in && w_ready;
  assign w_acc_rd     = w_accept && !request_write_in;
  assign w_acc_wr     = w_accept && request_write_in;
  assign w_resp_valid = !reset_in && (r_count != 3'd0);
  assign w_pop        = w_resp_valid && response_ready_in;
  assign w_push_data  = r_tag_write ? evict_element_in : read_element_in;

  assign request_ready_out     = w_ready;
  assign init_done_out         = w_run;
  assign read_en_out           = w_acc_rd;
  assign read_set_addr_out     = w_acc_rd ? request_set_addr_in : '0;
  assign write_en_out          = w_init_wr || w_acc_wr;
  assign write_set_addr_out    = w_init_wr ? r_init_ptr : (w_acc_wr ? request_set_addr_in : '0);
  assign write_element_out     = w_acc_wr ? request_data_in : '0;
  assign response_valid_out    = w_resp_valid;
  assign response_write_out    = w_resp_valid && r_fifo_write[r_rd_ptr];
  assign response_set_addr_out = w_resp_valid ? r_fifo_addr[r_rd_ptr] : '0;
  assign response_data_out     = w_resp_valid ? r_fifo_data[r_rd_ptr] : '0;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state     <= ST_INIT;
      r_init_ptr  <= '0;
      r_inflight  <= 1'b0;
      r_tag_write <= 1'b0;
      r_tag_addr  <= '0;
      r_count     <= 3'd0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_ptr <= r_init_ptr + 1'b1;
        if (r_init_ptr == LAST_SET) r_state <= ST_RUN;
      end
      // Tag travels one cycle to line up with the blockram's registered data.
      r_inflight <= w_accept;
      if (w_accept) begin
        r_tag_write <= request_write_in;
        r_tag_addr  <= request_set_addr_in;
      end
      if (r_inflight) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= r_count + {2'b00, r_inflight} - {2'b00, w_pop};
    end
  end

  always_ff @(posedge clk_in) begin
    if (r_inflight) begin
      r_fifo_data[r_wr_ptr]  <= w_push_data;
      r_fifo_write[r_wr_ptr] <= r_tag_write;
      r_fifo_addr[r_wr_ptr]  <= r_tag_addr;
    end
  end

endmodule

// File: tb/tb_dual_port_blockram_controller.sv
`timescale 1ns/1ps
// Bench for dual_port_blockram_controller: behavioural blockram, an in-order response
// scoreboard checked every cycle, and directed plus randomized request traffic.
module tb_dual_port_blockram_controller;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        request_valid_in;
  logic        request_ready_out;
  logic        request_write_in;
  logic [5:0]  request_set_addr_in;
  logic [63:0] request_data_in;
  logic        response_valid_out;
  logic        response_ready_in;
  logic        response_write_out;
  logic [5:0]  response_set_addr_out;
  logic [63:0] response_data_out;
  logic        read_en_out;
  logic [5:0]  read_set_addr_out;
  logic [63:0] read_element_in;
  logic        write_en_out;
  logic [5:0]  write_set_addr_out;
  logic [63:0] write_element_out;
  logic [63:0] evict_element_in;
  logic        init_done_out;

  dual_port_blockram_controller dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .request_valid_in(request_valid_in), .request_ready_out(request_ready_out),
    .request_write_in(request_write_in), .request_set_addr_in(request_set_addr_in),
    .request_data_in(request_data_in),
    .response_valid_out(response_valid_out), .response_ready_in(response_ready_in),
    .response_write_out(response_write_out), .response_set_addr_out(response_set_addr_out),
    .response_data_out(response_data_out),
    .read_en_out(read_en_out), .read_set_addr_out(read_set_addr_out),
    .read_element_in(read_element_in),
    .write_en_out(write_en_out), .write_set_addr_out(write_set_addr_out),
    .write_element_out(write_element_out), .evict_element_in(evict_element_in),
    .init_done_out(init_done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        w;
    logic [5:0]  a;
    logic [63:0] d;
    int          cyc;
  } rsp_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rr_mode = 1;
  rsp_t        exp_q[$];
  rsp_t        got_q[$];
  logic [63:0] ref_mem [64];
  logic [63:0] bram [64];

  always @(posedge clk_in) cyc <= cyc + 1;

  // Blockram: registered read and evict data; scrambled during reset so the zero-fill is observable.
  always @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < 64; i++) bram[i] <= {$urandom(), $urandom()};
    end else begin
      if (read_en_out) read_element_in <= bram[read_set_addr_out];
      if (write_en_out) begin
        evict_element_in <= bram[write_set_addr_out];
        bram[write_set_addr_out] <= write_element_out;
      end
    end
  end

  initial forever begin
    @(posedge clk_in);
    #2;
    response_ready_in = (rr_mode == 2) ? 1'($urandom() % 2) : (rr_mode == 1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: outstanding responses in request order, each due two cycles after its accept.
  initial begin : model
    int   init_cnt;
    logic exp_ready, exp_valid, acc, w;
    logic [5:0]  a;
    logic [63:0] d;
    rsp_t r;
    init_cnt = 0;
    forever begin
      @(negedge clk_in);
      if (reset_in === 1'b1) begin
        chk("rst_req_ready", request_ready_out, 0);
        chk("rst_resp_valid", response_valid_out, 0);
        chk("rst_resp_data", response_data_out, 0);
        chk("rst_read_en", read_en_out, 0);
        chk("rst_write_en", write_en_out, 0);
        chk("rst_write_addr", write_set_addr_out, 0);
        chk("rst_write_elem", write_element_out, 0);
        chk("rst_init_done", init_done_out, 0);
        exp_q.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        init_cnt = 0;
      end else if (init_cnt < 64) begin
        chk("init_write_en", write_en_out, 1);
        chk("init_write_addr", write_set_addr_out, init_cnt);
        chk("init_write_elem", write_element_out, 0);
        chk("init_read_en", read_en_out, 0);
        chk("init_req_ready", request_ready_out, 0);
        chk("init_done_early", init_done_out, 0);
        chk("init_resp_valid", response_valid_out, 0);
        init_cnt++;
      end else begin
        exp_ready = (exp_q.size() < 4);
        acc       = request_valid_in && exp_ready;
        w         = request_write_in;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
        chk("init_done", init_done_out, 1);
        chk("req_ready", request_ready_out, exp_ready);
        chk("resp_valid", response_valid_out, exp_valid);
        chk("read_en", read_en_out, acc && !w);
        chk("write_en", write_en_out, acc && w);
        if (exp_valid) begin
          chk("resp_write", response_write_out, exp_q[0].w);
          chk("resp_addr", response_set_addr_out, exp_q[0].a);
          chk("resp_data", response_data_out, exp_q[0].d);
          if (response_ready_in === 1'b1) begin
            got_q.push_back('{w: response_write_out, a: response_set_addr_out,
                              d: response_data_out, cyc: cyc});
            void'(exp_q.pop_front());
          end
        end
        if (acc) begin
          a = request_set_addr_in;
          d = ref_mem[a];
          if (w) begin
            chk("write_addr", write_set_addr_out, a);
            chk("write_elem", write_element_out, request_data_in);
            ref_mem[a] = request_data_in;
          end else begin
            chk("read_addr", read_set_addr_out, a);
          end
          r = '{w: w, a: a, d: d, cyc: cyc};
          exp_q.push_back(r);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    request_valid_in = 1'b0;
    step(n);
  endtask

  task automatic send(input logic w, input logic [5:0] a, input logic [63:0] d, output int waited);
    request_valid_in    = 1'b1;
    request_write_in    = w;
    request_set_addr_in = a;
    request_data_in     = d;
    waited = 0;
    @(negedge clk_in);
    while (request_ready_out !== 1'b1 && waited < 100) begin
      waited++;
      @(posedge clk_in);
      #1;
      @(negedge clk_in);
    end
    chk("send_bound", waited < 100, 1);
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_init();
    int k = 0;
    @(negedge clk_in);
    while (init_done_out !== 1'b1 && k < 200) begin
      k++;
      @(negedge clk_in);
    end
    chk("init_cycles", k, 64);
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    request_valid_in = 1'b0;
    while (exp_q.size() != 0 && k < 200) begin
      step(1);
      k++;
    end
    chk("drain_bound", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   wt, cnt;
    logic [5:0] la, ra;
    reset_in            = 1'b1;
    request_valid_in    = 1'b0;
    request_write_in    = 1'b0;
    request_set_addr_in = '0;
    request_data_in     = '0;
    response_ready_in   = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    wait_init();

    // zero-filled array reads back 0
    got_q.delete();
    send(1'b0, 6'd17, 64'd0, wt);
    drain();
    chk("zero_rsp_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      chk("zero_rsp_addr", got_q[0].a, 17);
      chk("zero_rsp_data", got_q[0].d, 0);
    end

    // write then read of set 5
    got_q.delete();
    send(1'b1, 6'd5, 64'hDEADBEEF_00000005, wt);
    send(1'b0, 6'd5, 64'd0, wt);
    drain();
    chk("wr_rd_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("wr_rsp_write", got_q[0].w, 1);
      chk("wr_rsp_evict", got_q[0].d, 0);
      chk("rd_rsp_write", got_q[1].w, 0);
      chk("rd_rsp_data", got_q[1].d, 64'hDEADBEEF_00000005);
    end

    // streaming: set i holds i, then 64 back-to-back reads
    for (int i = 0; i < 64; i++) send(1'b1, 6'(i), 64'(i), wt);
    drain();
    got_q.delete();
    for (int i = 0; i < 64; i++) begin
      send(1'b0, 6'(i), 64'd0, wt);
      chk("stream_ready_stall", wt, 0);
    end
    drain();
    chk("stream_count", got_q.size(), 64);
    for (int i = 0; i < got_q.size(); i++) chk("stream_data", got_q[i].d, i);

    // backpressure: four accepts, stall, single pop frees one slot
    got_q.delete();
    rr_mode = 0;
    for (int i = 1; i <= 4; i++) begin
      send(1'b0, 6'(i), 64'd0, wt);
      chk("bp_accept_wait", wt, 0);
    end
    request_valid_in    = 1'b1;
    request_write_in    = 1'b0;
    request_set_addr_in = 6'd9;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      if (request_ready_out === 1'b1) cnt++;
      step(1);
    end
    chk("bp_stall_accepts", cnt, 0);
    rr_mode = 1;
    step(1);
    rr_mode = 0;
    @(negedge clk_in);
    chk("bp_ready_after_pop", request_ready_out, 1);
    step(1);
    request_valid_in = 1'b0;
    rr_mode = 1;
    drain();
    chk("bp_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      chk("bp_addr0", got_q[0].a, 1);
      chk("bp_data3", got_q[3].d, 4);
      chk("bp_addr4", got_q[4].a, 9);
      chk("bp_data4", got_q[4].d, 9);
    end

    // reset with three responses queued
    rr_mode = 0;
    for (int i = 1; i <= 3; i++) send(1'b0, 6'(i), 64'd0, wt);
    idle(4);
    @(negedge clk_in);
    chk("queued_valid", response_valid_out, 1);
    @(posedge clk_in);
    #1;
    reset_in = 1'b1;
    step(1);
    reset_in = 1'b0;
    rr_mode = 1;
    got_q.delete();
    wait_init();
    for (int i = 1; i <= 3; i++) send(1'b0, 6'(i), 64'd0, wt);
    drain();
    chk("rst_reread_count", got_q.size(), 3);
    for (int i = 0; i < got_q.size(); i++) chk("rst_reread_data", got_q[i].d, 0);

    // randomized traffic with random response backpressure
    rr_mode = 2;
    la = 6'd0;
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom() % 4 == 0) ? la : 6'($urandom() % 64);
      send(1'($urandom() % 2), ra, {$urandom(), $urandom()}, wt);
      la = ra;
      if ($urandom() % 4 == 0) idle($urandom() % 3 + 1);
    end
    rr_mode = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dual_port_blockram_controller.md
# dual_port_blockram_controller

Request-side controller for `dual_port_blockram`. It accepts a single valid/ready stream of read and write requests and drives the blockram read and write ports. It returns read data, and the evicted old contents on writes, through a buffered valid/ready response stream. After every reset it zero-fills the whole array before accepting traffic. The block sits between a cache/pipeline client and one `dual_port_blockram` instance.

## Interface
- SINGLE_ELEMENT_SIZE_IN_BITS, 64, element width
- NUMBER_SETS, 64, number of addressable sets
- SET_PTR_WIDTH_IN_BITS, 6, set address width, log2(NUMBER_SETS)

Ports:
- clk_in  input  1  single clock, all logic on rising edge
- reset_in  input  1  synchronous, active-high reset
- request_valid_in  input  1  request present
- request_ready_out  output  1  request accepted when valid & ready
- request_write_in  input  1  1 = write, 0 = read
- request_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  target set
- request_data_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  write data
- response_valid_out  output  1  response at FIFO head
- response_ready_in  input  1  consumer pops head when valid & ready
- response_write_out  output  1  1 = evicted data of a write, 0 = read data
- response_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  set of the response
- response_data_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  read or evicted element
- read_en_out, read_set_addr_out  output  1 / SET_PTR_WIDTH_IN_BITS  to blockram read port
- read_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  blockram read data, valid cycle after read_en
- write_en_out, write_set_addr_out, write_element_out  output  1 / SET_PTR_WIDTH_IN_BITS / SINGLE_ELEMENT_SIZE_IN_BITS  to blockram write port
- evict_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  old contents of written set, valid cycle after write_en
- init_done_out  output  1  high once zero-fill completes

## Operation
- FSM states: INIT, RUN.
- **Reset:** reset enters INIT with init_ptr = 0, FIFO empty, inflight = 0.
- **INIT:**
  - Each cycle: write_en_out=1, write_set_addr_out=init_ptr, write_element_out=0; init_ptr increments.
  - When init_ptr == NUMBER_SETS-1 is written, go to RUN next cycle.
  - Evict data from INIT writes is discarded, never enqueued.
  - request_ready_out=0 throughout.
- **RUN:**
  - request_ready_out = (fifo_count + inflight) < 4, with inflight ∈ {0,1}. A same-cycle pop is not credited.
  - On accept the port is driven combinationally in the same cycle:
    - Read: read_en_out=1, read_set_addr_out=addr.
    - Write: write_en_out=1, write_set_addr_out=addr, write_element_out=data.
    - At most one port is active per cycle; read and write are never simultaneous.
  - Accept registers the inflight tag {write, addr} for one cycle.
  - Next cycle, the tag and the selected data (read_element_in or evict_element_in) are pushed into a 4-entry FIFO.
  - FIFO head drives response_*; pop on response_valid_out & response_ready_in. Push and pop in the same cycle are allowed.
- Responses are returned in request order. No reordering, no forwarding.
- Reset at any time, including mid-INIT or with responses queued: all state is discarded and the sweep restarts at set 0.

## Timing
- **Reset values:**
  - All of these are 0: request_ready_out, response_valid_out, response_write_out, response_set_addr_out, response_data_out, read_en_out, read_set_addr_out, write_en_out, write_set_addr_out, write_element_out, init_done_out.
  - write_en_out rises in the first cycle after reset deasserts (INIT write of set 0).
- **INIT duration:** exactly NUMBER_SETS cycles. init_done_out and first possible request_ready_out=1 occur in cycle NUMBER_SETS after reset release.
- **Latency:** request accepted in cycle T → blockram data sampled at end of T+1 → response_valid_out=1 in T+2.
- **Throughput:** with response_ready_in held 1, one request per cycle sustained indefinitely; fifo_count + inflight never exceeds 2.
- **Backpressure:** with response_ready_in=0, exactly 4 requests are accepted, then request_ready_out=0 until a pop. After a pop, ready returns the following cycle.
- **Read after write, same set, back-to-back:** the read observes the new data. This relies on the blockram completing the write at the edge ending cycle T.

## Test plan
- **Zero-fill:** release reset → 64 consecutive write_en_out cycles, addr 0..63, data 0; init_done_out=1 at cycle 64. A subsequent read of set 17 returns 0.
- **Write then read:** write set 5 = 0xDEADBEEF_00000005, then read set 5 → responses in order: {write=1, addr 5, data 0 (evicted)}, then {write=0, addr 5, data 0xDEADBEEF_00000005}, each 2 cycles after its accept.
- **Streaming:** response_ready_in=1, 64 back-to-back reads after writing data=i to set i → request_ready_out never drops; response i is valid in cycle accept+2 with data i.
- **Backpressure:** response_ready_in=0, request_valid_in held → exactly 4 accepts, then ready=0. Raise response_ready_in for 1 cycle → one pop, ready=1 the next cycle, and no response is lost or duplicated.
- **Reset mid-traffic:** assert reset with 3 responses queued → response_valid_out=0 the next cycle, FIFO empty, INIT restarts at set 0. Re-read of previously written sets returns 0.
